tx_arbiter: RTL and testbench

//  Shares the single serial transmit path (tx controller + shift register + bit counter)

---
 rtl/tx_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/tx_arbiter.sv | 130 +++++++++++++
 tb/tb_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the serial transmit path: FSM encodings, default byte width
// and the baud-counter width helper used by the tx controller, tx counter and arbiter.
package tx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    WAIT = ST_WAIT,
    GAP  = ST_GAP
  } tx_state_t;

  localparam int unsigned DW_DEFAULT = 8;

  // Width of a saturating counter that must reach the larger of two terminal counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr, wrapping.
// Reusable for any requester count; no state is kept here.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          valid_c
);

  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned   pos;
      logic [IW-1:0] sel;
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      sel = IW'(pos);
      if (!valid_c && req[sel]) begin
        valid_c    = 1'b1;
        idx_c      = sel;
        gnt_c[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin owner of the shared serial transmit path: latches the winner's byte,
// strobes the tx controller, waits for frame done (with watchdog) and enforces a baud gap.
module tx_arbiter
  import tx_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned DW            = DW_DEFAULT,
  parameter int unsigned GAP_BAUDS     = 2,
  parameter int unsigned TIMEOUT_BAUDS = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               baud,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data_in,
  input  logic               tx_done,
  output logic               tx_pulse,
  output logic [DW-1:0]      tx_data,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    ack,
  output logic               busy,
  output logic               timeout
);

  localparam int unsigned   IW          = $clog2(NREQ);
  localparam int unsigned   CW          = cnt_width(GAP_BAUDS, TIMEOUT_BAUDS);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_BAUDS - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_BAUDS - 1);
  localparam tx_state_t     AFTER_FRAME = (GAP_BAUDS > 0) ? GAP : IDLE;

  tx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            tx_pulse_d, busy_d, timeout_d;
  logic [DW-1:0]   tx_data_d;
  logic [NREQ-1:0] grant_d, ack_d;

  logic [NREQ-1:0] pick_gnt_c;
  logic [IW-1:0]   pick_idx_c;
  logic            pick_valid_c;
  logic [DW-1:0]   pick_data_c;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_c   (pick_gnt_c),
    .idx_c   (pick_idx_c),
    .valid_c (pick_valid_c)
  );

  // One-hot AND-OR mux of the winner's byte.
  always_comb begin
    pick_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt_c[i]) pick_data_c = pick_data_c | data_in[i*DW +: DW];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data;
    grant_d    = grant;
    ack_d      = '0;
    tx_pulse_d = 1'b0;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    if (baud && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          state_d    = LOAD;
          ptr_d      = pick_idx_c;
          tx_data_d  = pick_data_c;
          grant_d    = pick_gnt_c;
          ack_d      = pick_gnt_c;
          tx_pulse_d = 1'b1;
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        // A done arriving with the final watchdog tick completes the frame normally.
        if (tx_done) begin
          state_d = AFTER_FRAME;
        end else if (baud && (cnt_q == TMO_LAST)) begin
          state_d   = AFTER_FRAME;
          timeout_d = 1'b1;
        end
      end
      GAP: begin
        if (baud && (cnt_q == GAP_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state entry, so the tick at the entry edge is dropped.
    if (state_d != state_q) cnt_d = '0;
    if ((state_d == IDLE) || (state_d == GAP)) grant_d = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= IW'(NREQ - 1);
      tx_pulse <= 1'b0;
      tx_data  <= '0;
      grant    <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      tx_pulse <= tx_pulse_d;
      tx_data  <= tx_data_d;
      grant    <= grant_d;
      ack      <= ack_d;
      busy     <= busy_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: frame-level reference model of round-robin order,
// latched data, watchdog and inter-frame gap timing, driven with randomized stimulus.
module tb_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             baud = 1'b0;
  logic             tx_done = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ*DW-1:0] data_in = '0;
  logic             tx_pulse, busy, timeout;
  logic [DW-1:0]    tx_data;
  logic [NREQ-1:0]  grant, ack;

  tx_arbiter #(
    .NREQ(NREQ), .DW(DW), .GAP_BAUDS(2), .TIMEOUT_BAUDS(16)
  ) dut (
    .clock(clock), .reset(reset), .baud(baud), .req(req), .data_in(data_in),
    .tx_done(tx_done), .tx_pulse(tx_pulse), .tx_data(tx_data), .grant(grant),
    .ack(ack), .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int m_last = NREQ - 1;
  logic [DW-1:0] lane [NREQ];
  logic [NREQ-1:0] exp_grant;

  // Reference rule: first pending requester after the previous winner, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick(input bit b, input bit d);
    baud = b; tx_done = d;
    @(posedge clock); #1;
    baud = 1'b0; tx_done = 1'b0;
  endtask

  task automatic new_data();
    for (int i = 0; i < NREQ; i++) if (!req[i]) lane[i] = 8'($urandom);
    data_in = {lane[3], lane[2], lane[1], lane[0]};
  endtask

  task automatic start_frame(input logic [NREQ-1:0] r, input bit hold, output int w);
    logic [NREQ-1:0] oh;
    w = model_pick(r, m_last);
    m_last = w;
    oh = 4'(1 << w);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
    req = r;
    tick(0, 0);
    n_cmp++; if (tx_pulse !== 1'b1) begin n_bad++; $display("FAIL load_pulse: got %b expected 1", tx_pulse); end
    n_cmp++; if (ack !== oh) begin n_bad++; $display("FAIL load_ack: got %b expected %b", ack, oh); end
    n_cmp++; if (grant !== oh) begin n_bad++; $display("FAIL load_grant: got %b expected %b", grant, oh); end
    n_cmp++; if (tx_data !== lane[w]) begin n_bad++; $display("FAIL load_data: got %h expected %h", tx_data, lane[w]); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL load_busy: got %b expected 1", busy); end
    if (!hold) req = r & ~oh;
    tick(0, 0);
    n_cmp++; if ({tx_pulse, ack} !== 5'b0) begin n_bad++; $display("FAIL wait_strobes: got %b expected 00000", {tx_pulse, ack}); end
    n_cmp++; if (grant !== oh) begin n_bad++; $display("FAIL wait_grant: got %b expected %b", grant, oh); end
    exp_grant = oh;
  endtask

  // n_done: 0..15 = done after that many ticks, 16 = done with the 16th tick, -1 = never.
  task automatic finish_wait(input int n_done);
    int ticks;
    ticks = (n_done < 0) ? 16 : ((n_done == 16) ? 15 : n_done);
    for (int k = 0; k < ticks; k++) begin
      repeat ($urandom_range(0, 2)) tick(0, 0);
      tick(1, 0);
      if (!(n_done < 0 && k == ticks - 1)) begin
        n_cmp++; if ({grant, timeout} !== {exp_grant, 1'b0}) begin
          n_bad++; $display("FAIL wait_hold: got %b expected %b", {grant, timeout}, {exp_grant, 1'b0});
        end
      end
    end
    if (n_done < 0) begin
      n_cmp++; if ({timeout, busy, grant} !== 6'b110000) begin
        n_bad++; $display("FAIL timeout_pulse: got %b expected 110000", {timeout, busy, grant});
      end
      tick(0, 0);
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_len: got %b expected 0", timeout); end
    end else begin
      repeat ($urandom_range(0, 2)) tick(0, 0);
      tick((n_done == 16) ? 1'b1 : 1'($urandom_range(0, 1)), 1);
      n_cmp++; if ({timeout, busy, grant} !== 6'b010000) begin
        n_bad++; $display("FAIL done_entry: got %b expected 010000", {timeout, busy, grant});
      end
    end
  endtask

  task automatic run_gap();
    for (int g = 0; g < 2; g++) begin
      repeat ($urandom_range(0, 2)) begin
        tick(0, 0);
        n_cmp++; if ({busy, tx_pulse} !== 2'b10) begin
          n_bad++; $display("FAIL gap_hold: got %b expected 10", {busy, tx_pulse});
        end
      end
      tick(1, 0);
      if (g == 0) begin
        n_cmp++; if ({busy, tx_pulse} !== 2'b10) begin
          n_bad++; $display("FAIL gap_first_tick: got %b expected 10", {busy, tx_pulse});
        end
      end else begin
        n_cmp++; if ({busy, tx_pulse, grant} !== 6'b0) begin
          n_bad++; $display("FAIL gap_exit: got %b expected 000000", {busy, tx_pulse, grant});
        end
      end
    end
  endtask

  task automatic frame(input logic [NREQ-1:0] r, input bit hold, input int n_done, output int w);
    start_frame(r, hold, w);
    finish_wait(n_done);
    run_gap();
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0;
    tick(0, 0); tick(0, 0);
    reset = 1'b1;
    m_last = NREQ - 1;
    tick(0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(0, 0); tick(0, 0);
    n_cmp++; if ({tx_pulse, grant, ack, busy, timeout, tx_data} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", {tx_pulse, grant, ack, busy, timeout, tx_data});
    end
    reset = 1'b1; m_last = NREQ - 1;
    tick(0, 0);
    repeat (3) tick(1, 0);
    n_cmp++; if ({busy, tx_pulse} !== 2'b00) begin n_bad++; $display("FAIL idle_no_req: got %b expected 00", {busy, tx_pulse}); end
  endtask

  task automatic test_single();
    int w;
    new_data();
    lane[0] = 8'hA5;
    data_in = {lane[3], lane[2], lane[1], lane[0]};
    frame(4'b0001, 0, 10, w);
  endtask

  task automatic test_fairness();
    int w;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    new_data();
    for (int i = 0; i < 5; i++) begin
      start_frame(4'b1111, 1, w);
      n_cmp++; if (w !== exp_order[i] || grant !== 4'(1 << exp_order[i])) begin
        n_bad++; $display("FAIL rr_order: got %b expected %b", grant, 4'(1 << exp_order[i]));
      end
      if (i == 4) req = '0;
      finish_wait(10);
      run_gap();
    end
  endtask

  task automatic test_gap_pending();
    int w;
    new_data();
    start_frame(4'b0100, 0, w);
    req = 4'b1000;
    new_data();
    finish_wait(3);
    run_gap();
    frame(4'b1000, 0, 5, w);
  endtask

  task automatic test_timeout();
    int w;
    new_data();
    frame(4'b0011, 0, -1, w);
    frame(req, 0, 6, w);
  endtask

  task automatic test_reset_mid();
    int w;
    new_data();
    start_frame(4'b0010, 0, w);
    repeat (3) tick(1, 0);
    reset = 1'b0;
    tick(0, 0);
    n_cmp++; if ({busy, grant, tx_pulse, ack, timeout, tx_data} !== '0) begin
      n_bad++; $display("FAIL reset_mid: got %h expected 0", {busy, grant, tx_pulse, ack, timeout, tx_data});
    end
    reset = 1'b1; m_last = NREQ - 1;
    new_data();
    frame(4'b0011, 0, 4, w);
    n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL reset_ptr: got %0d expected 0", w); end
  endtask

  task automatic test_coincide();
    int w;
    new_data();
    frame(4'b0100, 0, 16, w);
  endtask

  task automatic test_random();
    int w, sel, nd;
    logic [NREQ-1:0] r;
    for (int i = 0; i < 20; i++) begin
      r = req | 4'($urandom_range(0, 15));
      if (r == '0) r = 4'b0001;
      new_data();
      sel = $urandom_range(0, 5);
      nd = (sel == 0) ? -1 : ((sel == 1) ? 16 : int'($urandom_range(0, 15)));
      frame(r, 1'($urandom_range(0, 1)), nd, w);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_gap_pending();
    test_timeout();
    test_reset_mid();
    test_coincide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
